// File: rtl/hsv_blob_tracker_pkg.sv
// Shared types, fixed-point helpers and window compares for the HSV blob tracker.
package hsv_blob_tracker_pkg;
    localparam int Q_FULL = 32;
    localparam int Q_HALF = 16;

    typedef enum logic [2:0] {IDLE, ACCUM, DIV_X, DIV_Y, DONE} state_t;
    typedef logic [Q_FULL-1:0] q_t;

    function automatic q_t q_one();
        return q_t'(1) << Q_HALF;
    endfunction

    function automatic q_t q_frac_mask();
        return q_one() - q_t'(1);
    endfunction

    function automatic q_t int_to_q(input int unsigned val);
        return q_t'(val) << Q_HALF;
    endfunction

    // Inclusive hue window; lo > hi wraps through zero (e.g. red 170..10).
    function automatic logic hue_in_window(input q_t h, input q_t lo, input q_t hi);
        if (lo <= hi) return (h >= lo) && (h <= hi);
        return (h >= lo) || (h <= hi);
    endfunction

    function automatic logic in_range(input q_t val, input q_t lo, input q_t hi);
        return (val >= lo) && (val <= hi);
    endfunction
endpackage

// File: rtl/division.sv
// Sequential restoring divider: quotient = (dividend << floating_bits) / divisor.
// No reset; one quotient bit per clock, busy while bits remain.
module division #(
    parameter int width         = 48,
    parameter int floating_bits = 16
) (
    input  logic             clk,
    input  logic             start,
    input  logic [width-1:0] dividend,
    input  logic [width-1:0] divisor,
    output logic             busy,
    output logic             valid,
    output logic             ovf,
    output logic [width-1:0] quotient
);
    localparam int nw = width + floating_bits;
    localparam int cw = $clog2(nw + 1);

    logic [nw-1:0]    num;
    logic [nw-1:0]    quo;
    logic [width-1:0] rem;
    logic [width-1:0] den;
    logic [cw-1:0]    cnt;
    logic             div_zero;
    logic [width:0]   trial;
    logic [width:0]   diff;
    logic             fits;

    assign trial = {rem, num[nw-1]};
    assign diff  = trial - {1'b0, den};
    assign fits  = trial >= {1'b0, den};

    always_ff @(posedge clk) begin
        if (start) begin
            num      <= {dividend, {floating_bits{1'b0}}};
            quo      <= '0;
            rem      <= '0;
            den      <= divisor;
            div_zero <= (divisor == '0);
            cnt      <= cw'(nw);
        end else if (cnt != '0) begin
            num <= num << 1;
            rem <= fits ? diff[width-1:0] : trial[width-1:0];
            quo <= {quo[nw-2:0], fits};
            cnt <= cnt - cw'(1);
        end
    end

    assign busy     = (cnt != '0);
    assign valid    = !div_zero;
    assign ovf      = |quo[nw-1:width];
    assign quotient = quo[width-1:0];
endmodule

// File: rtl/hsv_window_compare.sv
// HSV window classifier: bounds latched on frame start, combinational hit, registered mask.
module hsv_window_compare
    import hsv_blob_tracker_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic latch,
    input  logic in_valid,
    input  q_t   h,
    input  q_t   s,
    input  q_t   v,
    input  q_t   h_lo,
    input  q_t   h_hi,
    input  q_t   s_lo,
    input  q_t   s_hi,
    input  q_t   v_lo,
    input  q_t   v_hi,
    output logic hit,
    output logic mask_bit,
    output logic mask_valid
);
    q_t h_lo_q, h_hi_q, s_lo_q, s_hi_q, v_lo_q, v_hi_q;
    q_t h_lo_e, h_hi_e, s_lo_e, s_hi_e, v_lo_e, v_hi_e;

    // A pixel arriving with frame_start is judged against the new window.
    always_comb begin
        h_lo_e = latch ? h_lo : h_lo_q;
        h_hi_e = latch ? h_hi : h_hi_q;
        s_lo_e = latch ? s_lo : s_lo_q;
        s_hi_e = latch ? s_hi : s_hi_q;
        v_lo_e = latch ? v_lo : v_lo_q;
        v_hi_e = latch ? v_hi : v_hi_q;
    end

    assign hit = hue_in_window(h, h_lo_e, h_hi_e) && in_range(s, s_lo_e, s_hi_e)
                 && in_range(v, v_lo_e, v_hi_e);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_lo_q     <= '0;
            h_hi_q     <= '0;
            s_lo_q     <= '0;
            s_hi_q     <= '0;
            v_lo_q     <= '0;
            v_hi_q     <= '0;
            mask_bit   <= 1'b0;
            mask_valid <= 1'b0;
        end else begin
            if (latch) begin
                h_lo_q <= h_lo;
                h_hi_q <= h_hi;
                s_lo_q <= s_lo;
                s_hi_q <= s_hi;
                v_lo_q <= v_lo;
                v_hi_q <= v_hi;
            end
            mask_valid <= in_valid;
            if (in_valid) mask_bit <= hit;
        end
    end
endmodule

// File: rtl/hsv_blob_tracker.sv
// Per-frame colour blob tracker: mask, count, bounding box, and centroid via a shared divider.
// state  | meaning
// IDLE   | after reset, waiting for first frame_start
// ACCUM  | accepting pixels into count/sums/bbox
// DIV_X  | dividing sum_x by count (waits for divider idle before starting)
// DIV_Y  | dividing sum_y by count
// DONE   | results valid and held until next frame_start
module hsv_blob_tracker
    import hsv_blob_tracker_pkg::*;
#(
    parameter int q_full  = 32,
    parameter int q_half  = 16,
    parameter int coord_w = 10,
    parameter int acc_w   = 48,
    parameter int verbose = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 frame_start,
    input  logic                 frame_end,
    input  logic                 pixel_valid,
    input  logic [q_full-1:0]    h,
    input  logic [q_full-1:0]    s,
    input  logic [q_full-1:0]    v,
    input  logic [coord_w-1:0]   x,
    input  logic [coord_w-1:0]   y,
    input  logic [q_full-1:0]    h_lo,
    input  logic [q_full-1:0]    h_hi,
    input  logic [q_full-1:0]    s_lo,
    input  logic [q_full-1:0]    s_hi,
    input  logic [q_full-1:0]    v_lo,
    input  logic [q_full-1:0]    v_hi,
    output logic                 mask_bit,
    output logic                 mask_valid,
    output logic [2*coord_w-1:0] blob_count,
    output logic [coord_w-1:0]   min_x,
    output logic [coord_w-1:0]   min_y,
    output logic [coord_w-1:0]   max_x,
    output logic [coord_w-1:0]   max_y,
    output logic [q_full-1:0]    cx,
    output logic [q_full-1:0]    cy,
    output logic                 result_valid,
    output logic                 empty,
    output logic                 div_error,
    output logic                 busy
);
    state_t state, state_next;
    logic issued, div_start, div_busy, div_busy_q, div_done, div_valid, div_ovf;
    logic hit, px_acc;
    logic [acc_w-1:0] sum_x, sum_y, sx_n, sy_n, dividend, divisor, quotient;
    logic [2*coord_w-1:0] cnt_n;
    logic [coord_w-1:0] mnx_n, mny_n, mxx_n, mxy_n;
    logic unused_ok;

    assign px_acc       = pixel_valid && (frame_start || state == ACCUM);
    assign busy         = (state == DIV_X) || (state == DIV_Y);
    assign result_valid = (state == DONE);
    assign div_done     = issued && div_busy_q && !div_busy;
    assign dividend     = ((state == DIV_Y) ? sum_y : sum_x) << q_half;
    assign divisor      = acc_w'(blob_count) << q_half;
    assign unused_ok    = ^{quotient[acc_w-1:q_full], verbose != 0};

    hsv_window_compare u_cmp (
        .clk(clk), .reset(reset), .latch(frame_start), .in_valid(px_acc),
        .h(h), .s(s), .v(v),
        .h_lo(h_lo), .h_hi(h_hi), .s_lo(s_lo), .s_hi(s_hi), .v_lo(v_lo), .v_hi(v_hi),
        .hit(hit), .mask_bit(mask_bit), .mask_valid(mask_valid)
    );

    division #(.width(acc_w), .floating_bits(q_half)) u_div (
        .clk(clk), .start(div_start), .dividend(dividend), .divisor(divisor),
        .busy(div_busy), .valid(div_valid), .ovf(div_ovf), .quotient(quotient)
    );

    // Clear happens before the same-cycle pixel is folded in; saturated count freezes sums.
    always_comb begin
        cnt_n = frame_start ? '0 : blob_count;
        sx_n  = frame_start ? '0 : sum_x;
        sy_n  = frame_start ? '0 : sum_y;
        mnx_n = frame_start ? '1 : min_x;
        mny_n = frame_start ? '1 : min_y;
        mxx_n = frame_start ? '0 : max_x;
        mxy_n = frame_start ? '0 : max_y;
        if (px_acc && hit) begin
            if (cnt_n != '1) begin
                cnt_n = cnt_n + (2*coord_w)'(1);
                sx_n  = sx_n + acc_w'(x);
                sy_n  = sy_n + acc_w'(y);
            end
            if (x < mnx_n) mnx_n = x;
            if (y < mny_n) mny_n = y;
            if (x > mxx_n) mxx_n = x;
            if (y > mxy_n) mxy_n = y;
        end
    end

    always_comb begin
        state_next = state;
        div_start  = 1'b0;
        case (state)
            ACCUM: if (frame_end) state_next = (cnt_n == '0) ? DONE : DIV_X;
            DIV_X: begin
                if (!issued && !div_busy) div_start = 1'b1;
                else if (div_done) state_next = DIV_Y;
            end
            DIV_Y: begin
                if (!issued && !div_busy) div_start = 1'b1;
                else if (div_done) state_next = DONE;
            end
            default: state_next = state;
        endcase
        if (frame_start) begin
            state_next = ACCUM;
            div_start  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            issued     <= 1'b0;
            div_busy_q <= 1'b0;
        end else begin
            state      <= state_next;
            div_busy_q <= div_busy;
            if (state_next != state) issued <= 1'b0;
            else if (div_start) issued <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blob_count <= '0;
            sum_x      <= '0;
            sum_y      <= '0;
            min_x      <= '1;
            min_y      <= '1;
            max_x      <= '0;
            max_y      <= '0;
            cx         <= '0;
            cy         <= '0;
            empty      <= 1'b0;
            div_error  <= 1'b0;
        end else begin
            blob_count <= cnt_n;
            sum_x      <= sx_n;
            sum_y      <= sy_n;
            min_x      <= mnx_n;
            min_y      <= mny_n;
            max_x      <= mxx_n;
            max_y      <= mxy_n;
            if (frame_start) begin
                cx        <= '0;
                cy        <= '0;
                empty     <= 1'b0;
                div_error <= 1'b0;
            end else begin
                if (state == ACCUM && frame_end && cnt_n == '0) empty <= 1'b1;
                if (div_done && state == DIV_X) cx <= quotient[q_full-1:0];
                if (div_done && state == DIV_Y) cy <= quotient[q_full-1:0];
                if (div_done) div_error <= div_error | div_ovf | !div_valid;
            end
        end
    end
endmodule

// File: tb/tb_hsv_blob_tracker.sv
// Directed bench for hsv_blob_tracker: classification, accumulation, centroid and restart cases.
module tb_hsv_blob_tracker;
    import hsv_blob_tracker_pkg::*;

    logic        clk = 1'b0;
    logic        reset, frame_start, frame_end, pixel_valid;
    logic [31:0] h, s, v, h_lo, h_hi, s_lo, s_hi, v_lo, v_hi;
    logic [9:0]  x, y;
    logic        mask_bit, mask_valid, result_valid, empty, div_error, busy;
    logic [19:0] blob_count;
    logic [9:0]  min_x, min_y, max_x, max_y;
    logic [31:0] cx, cy;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hsv_blob_tracker dut (
        .clk(clk), .reset(reset), .frame_start(frame_start), .frame_end(frame_end),
        .pixel_valid(pixel_valid), .h(h), .s(s), .v(v), .x(x), .y(y),
        .h_lo(h_lo), .h_hi(h_hi), .s_lo(s_lo), .s_hi(s_hi), .v_lo(v_lo), .v_hi(v_hi),
        .mask_bit(mask_bit), .mask_valid(mask_valid), .blob_count(blob_count),
        .min_x(min_x), .min_y(min_y), .max_x(max_x), .max_y(max_y), .cx(cx), .cy(cy),
        .result_valid(result_valid), .empty(empty), .div_error(div_error), .busy(busy)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_window(input int unsigned hl, input int unsigned hh, input int unsigned sl,
                              input int unsigned sh, input int unsigned vl, input int unsigned vh);
        h_lo = int_to_q(hl); h_hi = int_to_q(hh);
        s_lo = int_to_q(sl); s_hi = int_to_q(sh);
        v_lo = int_to_q(vl); v_hi = int_to_q(vh);
    endtask

    task automatic start_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic end_frame();
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
    endtask

    task automatic drive_pixel(input int unsigned hh, input int unsigned ss, input int unsigned vv,
                               input logic [9:0] xx, input logic [9:0] yy, input logic fe);
        h = int_to_q(hh); s = int_to_q(ss); v = int_to_q(vv);
        x = xx; y = yy;
        pixel_valid = 1'b1;
        frame_end = fe;
        tick();
        pixel_valid = 1'b0;
        frame_end = 1'b0;
    endtask

    task automatic wait_result(input int budget, output logic ok, output logic saw_busy);
        ok = 1'b0;
        saw_busy = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (busy) saw_busy = 1'b1;
            if (result_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++; if (blob_count !== 20'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", blob_count); end
        checks++; if (min_x !== 10'h3ff) begin failures++; $display("FAIL rst_min_x got=%h exp=3ff", min_x); end
        checks++; if (min_y !== 10'h3ff) begin failures++; $display("FAIL rst_min_y got=%h exp=3ff", min_y); end
        checks++; if (max_x !== 10'd0) begin failures++; $display("FAIL rst_max_x got=%0d exp=0", max_x); end
        checks++; if ({busy, result_valid, mask_valid, empty, div_error} !== 5'b0) begin
            failures++; $display("FAIL rst_flags got=%b exp=00000", {busy, result_valid, mask_valid, empty, div_error}); end
        checks++; if ({cx, cy} !== 64'd0) begin failures++; $display("FAIL rst_centroid got=%h exp=0", {cx, cy}); end
        reset = 1'b0;
        tick();
        set_window(30, 90, 50, 255, 50, 255);
        drive_pixel(60, 200, 200, 10'd5, 10'd5, 1'b0);
        checks++; if (mask_valid !== 1'b0) begin failures++; $display("FAIL idle_pixel_mask_valid got=%b exp=0", mask_valid); end
        checks++; if (blob_count !== 20'd0) begin failures++; $display("FAIL idle_pixel_count got=%0d exp=0", blob_count); end
    endtask

    task automatic test_basic();
        logic ok, sb;
        set_window(30, 90, 50, 255, 50, 255);
        start_frame();
        set_window(0, 0, 0, 0, 0, 0);
        drive_pixel(60, 200, 200, 10'd10, 10'd20, 1'b0);
        checks++; if ({mask_valid, mask_bit} !== 2'b11) begin failures++; $display("FAIL t1_mask got=%b exp=11", {mask_valid, mask_bit}); end
        drive_pixel(60, 200, 200, 10'd30, 10'd40, 1'b0);
        end_frame();
        wait_result(400, ok, sb);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL t1_timeout got=%b exp=1", ok); end
        checks++; if (sb !== 1'b1) begin failures++; $display("FAIL t1_busy_seen got=%b exp=1", sb); end
        checks++; if (blob_count !== 20'd2) begin failures++; $display("FAIL t1_count got=%0d exp=2", blob_count); end
        checks++; if ({min_x, max_x, min_y, max_y} !== {10'd10, 10'd30, 10'd20, 10'd40}) begin
            failures++; $display("FAIL t1_bbox got=%0d,%0d,%0d,%0d exp=10,30,20,40", min_x, max_x, min_y, max_y); end
        checks++; if (cx !== 32'h0014_0000) begin failures++; $display("FAIL t1_cx got=%h exp=00140000", cx); end
        checks++; if (cy !== 32'h001e_0000) begin failures++; $display("FAIL t1_cy got=%h exp=001e0000", cy); end
        checks++; if ({empty, div_error} !== 2'b00) begin failures++; $display("FAIL t1_flags got=%b exp=00", {empty, div_error}); end
        tick(); tick(); tick();
        checks++; if ({result_valid, cx} !== {1'b1, 32'h0014_0000}) begin
            failures++; $display("FAIL t1_hold got=%b/%h exp=1/00140000", result_valid, cx); end
    endtask

    task automatic test_wrap();
        int unsigned th[7] = '{175, 5, 90, 170, 10, 11, 175};
        int unsigned ts[7] = '{200, 200, 200, 50, 200, 200, 49};
        int unsigned tx[7] = '{1, 3, 9, 2, 0, 9, 9};
        int unsigned ty[7] = '{1, 5, 9, 0, 0, 9, 9};
        logic        te[7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic ok, sb;
        set_window(170, 10, 50, 255, 50, 255);
        start_frame();
        for (int i = 0; i < 7; i++) begin
            drive_pixel(th[i], ts[i], 200, tx[i][9:0], ty[i][9:0], 1'b0);
            checks++; if ({mask_valid, mask_bit} !== {1'b1, te[i]}) begin
                failures++; $display("FAIL t2_mask[%0d] got=%b exp=1%b", i, {mask_valid, mask_bit}, te[i]); end
        end
        end_frame();
        wait_result(400, ok, sb);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL t2_timeout got=%b exp=1", ok); end
        checks++; if (blob_count !== 20'd4) begin failures++; $display("FAIL t2_count got=%0d exp=4", blob_count); end
        checks++; if ({min_x, max_x, min_y, max_y} !== {10'd0, 10'd3, 10'd0, 10'd5}) begin
            failures++; $display("FAIL t2_bbox got=%0d,%0d,%0d,%0d exp=0,3,0,5", min_x, max_x, min_y, max_y); end
        checks++; if ({cx, cy} !== {32'h0001_8000, 32'h0001_8000}) begin
            failures++; $display("FAIL t2_centroid got=%h/%h exp=00018000/00018000", cx, cy); end
    endtask

    task automatic test_empty();
        set_window(30, 90, 50, 255, 50, 255);
        start_frame();
        drive_pixel(120, 200, 200, 10'd4, 10'd4, 1'b0);
        checks++; if ({mask_valid, mask_bit} !== 2'b10) begin failures++; $display("FAIL t3_mask got=%b exp=10", {mask_valid, mask_bit}); end
        end_frame();
        checks++; if ({result_valid, empty, busy} !== 3'b110) begin
            failures++; $display("FAIL t3_flags got=%b exp=110", {result_valid, empty, busy}); end
        checks++; if ({cx, cy} !== 64'd0) begin failures++; $display("FAIL t3_centroid got=%h exp=0", {cx, cy}); end
        checks++; if ({min_x, max_x, blob_count} !== {10'h3ff, 10'd0, 20'd0}) begin
            failures++; $display("FAIL t3_bbox got=%h,%0d,%0d exp=3ff,0,0", min_x, max_x, blob_count); end
    endtask

    task automatic test_end_same_cycle();
        logic ok, sb;
        start_frame();
        drive_pixel(60, 200, 200, 10'd7, 10'd3, 1'b1);
        checks++; if ({busy, result_valid} !== 2'b10) begin failures++; $display("FAIL t4_busy got=%b exp=10", {busy, result_valid}); end
        wait_result(400, ok, sb);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL t4_timeout got=%b exp=1", ok); end
        checks++; if (blob_count !== 20'd1) begin failures++; $display("FAIL t4_count got=%0d exp=1", blob_count); end
        checks++; if ({cx, cy} !== {32'h0007_0000, 32'h0003_0000}) begin
            failures++; $display("FAIL t4_centroid got=%h/%h exp=00070000/00030000", cx, cy); end
    endtask

    task automatic test_reset_div_y();
        logic ok, sb;
        start_frame();
        drive_pixel(60, 200, 200, 10'd100, 10'd200, 1'b0);
        drive_pixel(60, 200, 200, 10'd300, 10'd400, 1'b0);
        end_frame();
        for (int i = 0; i < 80; i++) tick();
        checks++; if ({busy, result_valid} !== 2'b10) begin failures++; $display("FAIL t5_in_div got=%b exp=10", {busy, result_valid}); end
        reset = 1'b1;
        #1;
        checks++; if ({busy, result_valid, blob_count} !== 22'd0) begin
            failures++; $display("FAIL t5_rst_state got=%b%b/%0d exp=00/0", busy, result_valid, blob_count); end
        checks++; if ({cx, min_x, max_x} !== {32'd0, 10'h3ff, 10'd0}) begin
            failures++; $display("FAIL t5_rst_regs got=%h,%h,%0d exp=0,3ff,0", cx, min_x, max_x); end
        tick();
        reset = 1'b0;
        start_frame();
        drive_pixel(60, 200, 200, 10'd4, 10'd8, 1'b0);
        drive_pixel(60, 200, 200, 10'd6, 10'd2, 1'b0);
        end_frame();
        wait_result(500, ok, sb);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL t5_timeout got=%b exp=1", ok); end
        checks++; if ({blob_count, cx, cy} !== {20'd2, 32'h0005_0000, 32'h0005_0000}) begin
            failures++; $display("FAIL t5_centroid got=%0d,%h,%h exp=2,00050000,00050000", blob_count, cx, cy); end
    endtask

    task automatic test_restart_div_x();
        logic ok, sb, early;
        start_frame();
        drive_pixel(60, 200, 200, 10'd100, 10'd100, 1'b0);
        end_frame();
        for (int i = 0; i < 10; i++) tick();
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL t6_in_div got=%b exp=1", busy); end
        h = int_to_q(60); s = int_to_q(200); v = int_to_q(200);
        x = 10'd50; y = 10'd60;
        frame_start = 1'b1;
        pixel_valid = 1'b1;
        tick();
        frame_start = 1'b0;
        pixel_valid = 1'b0;
        checks++; if ({busy, result_valid, mask_valid} !== 3'b001) begin
            failures++; $display("FAIL t6_restart_flags got=%b exp=001", {busy, result_valid, mask_valid}); end
        checks++; if ({blob_count, min_x} !== {20'd1, 10'd50}) begin
            failures++; $display("FAIL t6_restart_acc got=%0d,%0d exp=1,50", blob_count, min_x); end
        early = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (result_valid) early = 1'b1;
            tick();
        end
        checks++; if (early !== 1'b0) begin failures++; $display("FAIL t6_stale_result got=%b exp=0", early); end
        end_frame();
        wait_result(400, ok, sb);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL t6_timeout got=%b exp=1", ok); end
        checks++; if ({blob_count, cx, cy} !== {20'd1, 32'h0032_0000, 32'h003c_0000}) begin
            failures++; $display("FAIL t6_centroid got=%0d,%h,%h exp=1,00320000,003c0000", blob_count, cx, cy); end
        drive_pixel(60, 200, 200, 10'd1, 10'd1, 1'b0);
        checks++; if ({mask_valid, blob_count} !== {1'b0, 20'd1}) begin
            failures++; $display("FAIL t6_done_pixel got=%b,%0d exp=0,1", mask_valid, blob_count); end
    endtask

    initial begin
        reset = 1'b1; frame_start = 1'b0; frame_end = 1'b0; pixel_valid = 1'b0;
        h = '0; s = '0; v = '0; x = '0; y = '0;
        h_lo = '0; h_hi = '0; s_lo = '0; s_hi = '0; v_lo = '0; v_hi = '0;
        test_reset();
        test_basic();
        test_wrap();
        test_empty();
        set_window(30, 90, 50, 255, 50, 255);
        test_end_same_cycle();
        test_reset_div_y();
        test_restart_div_x();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
